time_date_sequencer: RTL and testbench

Time-of-day and calendar register sequencer for the digital clock with date. It sits directly downstream of the 1 Hz time-update controller and advances seconds, minutes, hours, day, month and year one field per clock cycle, the same one-operation-per-cycle cadence as the 6-bit ALU datapath. It also accepts validated field writes from the timer-set path and feeds the display and timer-compare stages.

---
 rtl/time_date_sequencer.sv | 152 +++++++++++++++
 tb/tb_time_date_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_date_sequencer.sv
// Time-of-day and calendar register sequencer: advances one field per cycle on a tick and accepts validated writes.
// Optional macro LEAP_YEAR_EN gives February 29 days when year[1:0]==0 (exact for 2000..2099).
module time_date_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [2:0] set_field,
    input  logic [6:0] set_value,
    output logic       set_err,
    input  logic       clr_ovf,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       busy,
    output logic       upd_done,
    output logic       day_roll,
    output logic       tick_ovf,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEC  = 3'd1,
        S_MIN  = 3'd2,
        S_HOUR = 3'd3,
        S_DAY  = 3'd4,
        S_MON  = 3'd5,
        S_YEAR = 3'd6
    } state_t;

    state_t     state, state_next;
    logic       pend;
    logic       leap_cur, leap_set;
    logic [4:0] cur_mlen;
    logic       set_ok, accept, last_step;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = leap ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

`ifdef LEAP_YEAR_EN
    assign leap_cur = (year[1:0] == 2'b00);
    assign leap_set = (set_value[1:0] == 2'b00);
`else
    assign leap_cur = 1'b0;
    assign leap_set = 1'b0;
`endif

    assign cur_mlen  = month_len(month, leap_cur);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (tick || pend) state_next = S_SEC;
            S_SEC:   state_next = (sec == 6'd59)     ? S_MIN  : S_IDLE;
            S_MIN:   state_next = (min == 6'd59)     ? S_HOUR : S_IDLE;
            S_HOUR:  state_next = (hour == 5'd23)    ? S_DAY  : S_IDLE;
            S_DAY:   state_next = (day == cur_mlen)  ? S_MON  : S_IDLE;
            S_MON:   state_next = (month == 4'd12)   ? S_YEAR : S_IDLE;
            S_YEAR:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Write handshake: a write transfers on a rising edge where set_valid && set_ready.
    // set_ready drops during an update, with a pending tick, or with a tick arriving, so ticks always win.
    always_comb begin
        busy      = (state != S_IDLE);
        set_ready = (state == S_IDLE) && !pend && !tick;
        accept    = set_valid && set_ready;
        last_step = (state != S_IDLE) && (state_next == S_IDLE);
    end

    // Month and year writes must keep the current day inside the resulting month.
    always_comb begin
        set_ok = 1'b0;
        case (set_field)
            3'd0: set_ok = (set_value < 7'd60);
            3'd1: set_ok = (set_value < 7'd60);
            3'd2: set_ok = (set_value < 7'd24);
            3'd3: set_ok = (set_value != 7'd0) && (set_value <= {2'b00, cur_mlen});
            3'd4: set_ok = (set_value != 7'd0) && (set_value <= 7'd12) &&
                           (day <= month_len(set_value[3:0], leap_cur));
            3'd5: set_ok = (set_value < 7'd100) && (day <= month_len(month, leap_set));
            default: set_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= 7'd0;
            pend     <= 1'b0;
            tick_ovf <= 1'b0;
            set_err  <= 1'b0;
            upd_done <= 1'b0;
            day_roll <= 1'b0;
        end else begin
            set_err  <= 1'b0;
            upd_done <= last_step;
            day_roll <= (state == S_DAY);
            if (state == S_IDLE) pend <= pend && tick;
            else if (tick)       pend <= 1'b1;
            if ((state != S_IDLE) && tick && pend) tick_ovf <= 1'b1;
            else if (clr_ovf)                      tick_ovf <= 1'b0;
            case (state)
                S_SEC:  sec   <= (sec == 6'd59)    ? 6'd0 : sec + 6'd1;
                S_MIN:  min   <= (min == 6'd59)    ? 6'd0 : min + 6'd1;
                S_HOUR: hour  <= (hour == 5'd23)   ? 5'd0 : hour + 5'd1;
                S_DAY:  day   <= (day == cur_mlen) ? 5'd1 : day + 5'd1;
                S_MON:  month <= (month == 4'd12)  ? 4'd1 : month + 4'd1;
                S_YEAR: year  <= (year == 7'd99)   ? 7'd0 : year + 7'd1;
                default: begin
                    if (accept) begin
                        if (!set_ok) begin
                            set_err <= 1'b1;
                        end else begin
                            case (set_field)
                                3'd0:    sec   <= set_value[5:0];
                                3'd1:    min   <= set_value[5:0];
                                3'd2:    hour  <= set_value[4:0];
                                3'd3:    day   <= set_value[4:0];
                                3'd4:    month <= set_value[3:0];
                                default: year  <= set_value;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_date_sequencer.sv
// Self-checking bench for time_date_sequencer: tick cascades, field writes, overflow and async reset.
module tb_time_date_sequencer;

    localparam int W = 33;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick, set_valid, clr_ovf;
    logic [2:0] set_field;
    logic [6:0] set_value;
    logic       set_ready, set_err;
    logic [5:0] sec, min;
    logic [4:0] hour, day;
    logic [3:0] month;
    logic [6:0] year;
    logic       busy, upd_done, day_roll, tick_ovf;
    logic [2:0] state_dbg;
    logic [W-1:0] dut_td;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    time_date_sequencer dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .set_valid(set_valid),
        .set_ready(set_ready), .set_field(set_field), .set_value(set_value),
        .set_err(set_err), .clr_ovf(clr_ovf), .sec(sec), .min(min), .hour(hour),
        .day(day), .month(month), .year(year), .busy(busy), .upd_done(upd_done),
        .day_roll(day_roll), .tick_ovf(tick_ovf), .state_dbg(state_dbg)
    );

    assign dut_td = {year, month, day, hour, min, sec};

    function automatic logic [W-1:0] pack(input logic [6:0] y, input logic [3:0] mo,
                                           input logic [4:0] d, input logic [4:0] h,
                                           input logic [5:0] mi, input logic [5:0] s);
        return {y, mo, d, h, mi, s};
    endfunction

    // ---------------- clock/reset and drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; tick = 1'b0; set_valid = 1'b0; clr_ovf = 1'b0;
        set_field = 3'd0; set_value = 7'd0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic drive_write(input logic [2:0] f, input logic [6:0] v);
        int guard = 0;
        while (!set_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!set_ready) begin
            n_vec++; n_err++;
            $display("FAIL write_ready_timeout: set_ready=%b required 1", set_ready);
        end
        set_valid = 1'b1; set_field = f; set_value = v;
        step();
        set_valid = 1'b0;
    endtask

    task automatic preload(input logic [6:0] y, input logic [3:0] mo, input logic [4:0] d,
                           input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
        drive_write(3'd3, 7'd1);
        drive_write(3'd4, {3'd0, mo});
        drive_write(3'd5, y);
        drive_write(3'd3, {2'd0, d});
        drive_write(3'd2, {2'd0, h});
        drive_write(3'd1, {1'b0, mi});
        drive_write(3'd0, {1'b0, s});
    endtask

    task automatic drive_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Steps until upd_done is seen (bounded); reports edges taken and day_roll pulses.
    task automatic run_update(output int cyc, output int rolls, output bit seen);
        cyc = 0; rolls = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            if (day_roll) rolls++;
            if (upd_done) seen = 1'b1;
        end
    endtask

    task automatic pop_check(input string name);
        logic [W-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: output td=%h with empty expected queue", name, dut_td);
        end else begin
            e = exp_q.pop_front();
            if (dut_td !== e) begin
                n_err++;
                $display("FAIL %s: td=%h required %h", name, dut_td, e);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (dut_td !== pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0)) begin
            n_err++; $display("FAIL reset_fields: td=%h required %h", dut_td, pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
        end
        n_vec++;
        if ({busy, upd_done, day_roll, tick_ovf, set_err} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: flags=%b required 00000", {busy, upd_done, day_roll, tick_ovf, set_err});
        end
        n_vec++;
        if (set_ready !== 1'b1 || state_dbg !== 3'd0) begin
            n_err++; $display("FAIL reset_ready: set_ready=%b state=%0d required 1/0", set_ready, state_dbg);
        end
    endtask

    task automatic test_single_tick();
        int busy_cnt = 0, done_cnt = 0, done_at = 0;
        apply_reset();
        exp_q.push_back(pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd1));
        drive_tick();
        if (busy) busy_cnt++;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (busy) busy_cnt++;
            if (upd_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = c;
                    pop_check("single_tick_td");
                end
            end
        end
        n_vec++;
        if (done_cnt !== 1 || done_at !== 1) begin
            n_err++; $display("FAIL single_tick_done: pulses=%0d at=%0d required 1 at 1", done_cnt, done_at);
        end
        n_vec++;
        if (busy_cnt !== 1) begin
            n_err++; $display("FAIL single_tick_busy: busy cycles=%0d required 1", busy_cnt);
        end
    endtask

    task automatic test_tick_priority();
        apply_reset();
        set_valid = 1'b1; set_field = 3'd0; set_value = 7'd30; tick = 1'b1;
        #1;
        n_vec++;
        if (set_ready !== 1'b0) begin
            n_err++; $display("FAIL tick_priority_ready: set_ready=%b required 0", set_ready);
        end
        step();
        tick = 1'b0; set_valid = 1'b0;
        step();
        exp_q.push_back(pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd1));
        pop_check("tick_priority_td");
        n_vec++;
        if (set_err !== 1'b0) begin
            n_err++; $display("FAIL tick_priority_err: set_err=%b required 0", set_err);
        end
    endtask

    task automatic test_rollover();
        int cyc, rolls;
        bit seen;
        apply_reset();
        preload(7'd99, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59);
        exp_q.push_back(pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
        drive_tick();
        run_update(cyc, rolls, seen);
        n_vec++;
        if (!seen || cyc !== 6) begin
            n_err++; $display("FAIL rollover_latency: seen=%b edges=%0d required 1/6", seen, cyc);
        end
        n_vec++;
        if (rolls !== 1) begin
            n_err++; $display("FAIL rollover_day_roll: pulses=%0d required 1", rolls);
        end
        pop_check("rollover_td");
    endtask

    task automatic test_february();
        int cyc, rolls;
        bit seen;
        apply_reset();
        preload(7'd24, 4'd2, 5'd28, 5'd23, 6'd59, 6'd59);
`ifdef LEAP_YEAR_EN
        exp_q.push_back(pack(7'd24, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0));
`else
        exp_q.push_back(pack(7'd24, 4'd3, 5'd1, 5'd0, 6'd0, 6'd0));
`endif
        drive_tick();
        run_update(cyc, rolls, seen);
        pop_check("feb_2024_td");
        preload(7'd23, 4'd2, 5'd28, 5'd23, 6'd59, 6'd59);
        exp_q.push_back(pack(7'd23, 4'd3, 5'd1, 5'd0, 6'd0, 6'd0));
        drive_tick();
        run_update(cyc, rolls, seen);
        pop_check("feb_2023_td");
        apply_reset();
        drive_write(3'd4, 7'd2);
        drive_write(3'd5, 7'd24);
        drive_write(3'd3, 7'd29);
        n_vec++;
`ifdef LEAP_YEAR_EN
        if (set_err !== 1'b0 || day !== 5'd29) begin
            n_err++; $display("FAIL feb29_write: err=%b day=%0d required 0/29", set_err, day);
        end
        drive_write(3'd5, 7'd25);
        n_vec++;
        if (set_err !== 1'b1 || year !== 7'd24) begin
            n_err++; $display("FAIL feb29_year_write: err=%b year=%0d required 1/24", set_err, year);
        end
`else
        if (set_err !== 1'b1 || day !== 5'd1) begin
            n_err++; $display("FAIL feb29_write: err=%b day=%0d required 1/1", set_err, day);
        end
`endif
    endtask

    task automatic test_writes();
        int unsigned tf [17] = '{1, 1, 7, 6, 4, 3, 3, 4, 3, 4, 5, 2, 2, 3, 4, 0, 5};
        int unsigned tv [17] = '{60, 59, 5, 0, 4, 31, 30, 1, 31, 2, 100, 24, 23, 0, 13, 59, 99};
        bit          te [17] = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0};
        logic [6:0] e_y = 7'd0;
        logic [3:0] e_mo = 4'd1;
        logic [4:0] e_d = 5'd1, e_h = 5'd0;
        logic [5:0] e_mi = 6'd0, e_s = 6'd0;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            if (!te[i]) begin
                case (tf[i])
                    0: e_s  = tv[i][5:0];
                    1: e_mi = tv[i][5:0];
                    2: e_h  = tv[i][4:0];
                    3: e_d  = tv[i][4:0];
                    4: e_mo = tv[i][3:0];
                    default: e_y = tv[i][6:0];
                endcase
            end
            exp_q.push_back(pack(e_y, e_mo, e_d, e_h, e_mi, e_s));
            drive_write(tf[i][2:0], tv[i][6:0]);
            n_vec++;
            if (set_err !== te[i]) begin
                n_err++; $display("FAIL write_err[%0d]: field=%0d value=%0d set_err=%b required %b", i, tf[i], tv[i], set_err, te[i]);
            end
            pop_check("write_td");
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        apply_reset();
        preload(7'd0, 4'd1, 5'd1, 5'd23, 6'd59, 6'd59);
        exp_q.push_back(pack(7'd0, 4'd1, 5'd2, 5'd0, 6'd0, 6'd0));
        exp_q.push_back(pack(7'd0, 4'd1, 5'd2, 5'd0, 6'd0, 6'd1));
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (upd_done) begin
                pops++;
                pop_check("back_to_back_td");
            end
        end
        n_vec++;
        if (pops !== 2) begin
            n_err++; $display("FAIL back_to_back_updates: updates=%0d required 2", pops);
        end
        n_vec++;
        if (tick_ovf !== 1'b1) begin
            n_err++; $display("FAIL back_to_back_ovf: tick_ovf=%b required 1", tick_ovf);
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        n_vec++;
        if (tick_ovf !== 1'b0) begin
            n_err++; $display("FAIL clr_ovf: tick_ovf=%b required 0", tick_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        apply_reset();
        preload(7'd0, 4'd1, 5'd1, 5'd23, 6'd59, 6'd59);
        tick = 1'b1;
        step(); step();
        tick = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || sec !== 6'd0 || min !== 6'd59) begin
            n_err++; $display("FAIL mid_cascade: busy=%b sec=%0d min=%0d required 1/0/59", busy, sec, min);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (dut_td !== pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0) || busy !== 1'b0) begin
            n_err++; $display("FAIL async_reset: td=%h busy=%b required %h/0", dut_td, busy, pack(7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
        end
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (upd_done) done_cnt++;
        end
        n_vec++;
        if (done_cnt !== 0 || sec !== 6'd0) begin
            n_err++; $display("FAIL reset_discards_pend: updates=%0d sec=%0d required 0/0", done_cnt, sec);
        end
    endtask

    initial begin
        test_reset();
        test_single_tick();
        test_tick_priority();
        test_rollover();
        test_february();
        test_writes();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
